// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: internal baud divider, N/O/E parity, 1-2 stop bits, LSB first.
// Optional line-break generator enabled with `define UART_TX_BREAK_EN.
module uart_tx_param #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_50M,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                 send_break,
`endif
  output logic                 tx_ready,
  output logic                 tx_d,
  output logic                 busy,
  output logic                 done
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

`ifdef UART_TX_BREAK_EN
  localparam int FRAME_LEN = (1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS) * DIV;
  localparam int BRK_W     = $clog2(FRAME_LEN);
  localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(FRAME_LEN - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
`ifdef UART_TX_BREAK_EN
    , BRK
`endif
  } state_t;

  state_t                 state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [3:0]             bit_r, bit_s;
  logic [DATA_BITS-1:0]   shift_r, shift_s;
  logic                   par_r, par_s;
  logic                   tx_d_r, tx_d_s;
  logic                   busy_r, busy_s;
  logic                   ready_r, ready_s;
  logic                   done_r, done_s;
  logic                   boundary_s;
`ifdef UART_TX_BREAK_EN
  logic [BRK_W-1:0]       brk_cnt_r, brk_cnt_s;
  logic                   brk_hi_r, brk_hi_s;
`endif

  // Odd parity inverts the XOR so the total count of ones on the line is odd.
  function automatic logic frame_parity(input logic [DATA_BITS-1:0] data);
    logic p;
    p = ^data;
    if (PARITY == 1) begin
      frame_parity = ~p;
    end else begin
      frame_parity = p;
    end
  endfunction

  assign tx_d     = tx_d_r;
  assign busy     = busy_r;
  assign tx_ready = ready_r;
  assign done     = done_r;

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      bit_r     <= 4'd0;
      shift_r   <= {DATA_BITS{1'b0}};
      par_r     <= 1'b0;
      tx_d_r    <= 1'b1;
      busy_r    <= 1'b0;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt_r <= {BRK_W{1'b0}};
      brk_hi_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_r     <= bit_s;
      shift_r   <= shift_s;
      par_r     <= par_s;
      tx_d_r    <= tx_d_s;
      busy_r    <= busy_s;
      ready_r   <= ready_s;
      done_r    <= done_s;
`ifdef UART_TX_BREAK_EN
      brk_cnt_r <= brk_cnt_s;
      brk_hi_r  <= brk_hi_s;
`endif
    end
  end

  // Next-state, baud counter and next line level; outputs are registered from these.
  always_comb begin
    state_s    = state_r;
    bit_s      = bit_r;
    shift_s    = shift_r;
    par_s      = par_r;
    tx_d_s     = tx_d_r;
    done_s     = 1'b0;
    boundary_s = (cnt_r == CNT_LAST);
`ifdef UART_TX_BREAK_EN
    brk_cnt_s  = brk_cnt_r;
    brk_hi_s   = brk_hi_r;
`endif
    if (state_r == IDLE) begin
      cnt_s = {CNT_W{1'b0}};
    end else if (boundary_s) begin
      cnt_s = {CNT_W{1'b0}};
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end

    case (state_r)
      IDLE: begin
        tx_d_s = 1'b1;
        bit_s  = 4'd0;
`ifdef UART_TX_BREAK_EN
        // A pending break outranks a pending word.
        if (send_break) begin
          state_s   = BRK;
          tx_d_s    = 1'b0;
          brk_cnt_s = {BRK_W{1'b0}};
          brk_hi_s  = 1'b0;
        end else
`endif
        if (tx_valid) begin
          state_s = START;
          shift_s = tx_data;
          par_s   = frame_parity(tx_data);
          tx_d_s  = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (boundary_s) begin
          state_s = DATA;
          tx_d_s  = shift_r[0];
        end else begin
          tx_d_s  = 1'b0;
        end
      end
      DATA: begin
        if (boundary_s) begin
          if (bit_r == DATA_LAST) begin
            bit_s = 4'd0;
            if (PARITY != 0) begin
              state_s = PAR;
              tx_d_s  = par_r;
            end else begin
              state_s = STOP;
              tx_d_s  = 1'b1;
            end
          end else begin
            bit_s   = bit_r + 4'd1;
            shift_s = shift_r >> 1;
            tx_d_s  = shift_r[1];
          end
        end else begin
          tx_d_s = shift_r[0];
        end
      end
      PAR: begin
        if (boundary_s) begin
          state_s = STOP;
          tx_d_s  = 1'b1;
          bit_s   = 4'd0;
        end else begin
          tx_d_s  = par_r;
        end
      end
      STOP: begin
        tx_d_s = 1'b1;
        if (boundary_s) begin
          if (bit_r == STOP_LAST) begin
            state_s = IDLE;
            done_s  = 1'b1;
            bit_s   = 4'd0;
          end else begin
            bit_s   = bit_r + 4'd1;
          end
        end else begin
          bit_s = bit_r;
        end
      end
`ifdef UART_TX_BREAK_EN
      BRK: begin
        if (brk_hi_r) begin
          tx_d_s = 1'b1;
          if (boundary_s) begin
            state_s  = IDLE;
            brk_hi_s = 1'b0;
          end else begin
            brk_hi_s = 1'b1;
          end
        end else begin
          tx_d_s = 1'b0;
          // Low phase lasts at least one frame time, longer while send_break stays high.
          if ((brk_cnt_r == BRK_LAST) && !send_break) begin
            brk_hi_s = 1'b1;
            tx_d_s   = 1'b1;
            cnt_s    = {CNT_W{1'b0}};
          end else if (brk_cnt_r != BRK_LAST) begin
            brk_cnt_s = brk_cnt_r + BRK_W'(1);
          end else begin
            brk_cnt_s = brk_cnt_r;
          end
        end
      end
`endif
      default: begin
        state_s = IDLE;
        tx_d_s  = 1'b1;
      end
    endcase

    busy_s  = (state_s != IDLE);
    ready_s = (state_s == IDLE);
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances (8N1 DIV=434, 7E2, 7O2, 8N1 DIV=4).
// Break generator is exercised when UART_TX_BREAK_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] td;
  logic       tv;
  logic       sb;
  int         sel;
  wire  [3:0] tx_d_v, busy_v, done_v, ready_v;
  int         checks = 0;
  int         errors = 0;

  always #10 clk = ~clk;

  uart_tx_param u_a (
    .clk_50M(clk), .rst_n(rst_n), .tx_data(td), .tx_valid(tv && (sel == 0)),
`ifdef UART_TX_BREAK_EN
    .send_break(sb && (sel == 0)),
`endif
    .tx_ready(ready_v[0]), .tx_d(tx_d_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  uart_tx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk_50M(clk), .rst_n(rst_n), .tx_data(td[6:0]), .tx_valid(tv && (sel == 1)),
`ifdef UART_TX_BREAK_EN
    .send_break(sb && (sel == 1)),
`endif
    .tx_ready(ready_v[1]), .tx_d(tx_d_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  uart_tx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
    .clk_50M(clk), .rst_n(rst_n), .tx_data(td[6:0]), .tx_valid(tv && (sel == 2)),
`ifdef UART_TX_BREAK_EN
    .send_break(sb && (sel == 2)),
`endif
    .tx_ready(ready_v[2]), .tx_d(tx_d_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  uart_tx_param #(.CLK_HZ(8), .BAUD(2)) u_d (
    .clk_50M(clk), .rst_n(rst_n), .tx_data(td), .tx_valid(tv && (sel == 3)),
`ifdef UART_TX_BREAK_EN
    .send_break(sb && (sel == 3)),
`endif
    .tx_ready(ready_v[3]), .tx_d(tx_d_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; sends one word and checks every line cycle against the bit pattern.
  task automatic run_frame(input string tag, input int div, input int nbits,
                           input logic [15:0] bits, input logic [7:0] data, input bit hold);
    int good;
    int dones;
    chk({tag, " ready"}, 32'(ready_v[sel]), 32'd1);
    td = data;
    tv = 1'b1;
    @(negedge clk);
    if (!hold) tv = 1'b0;
    td = ~data;
    dones = 0;
    for (int b = 0; b < nbits; b++) begin
      good = 0;
      for (int c = 0; c < div; c++) begin
        if (tx_d_v[sel] === bits[b]) good++;
        if (done_v[sel] === 1'b1) dones++;
        if (!hold && b == 3 && c == 0) tv = 1'b1;
        if (!hold && b == 3 && c == 1) tv = 1'b0;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d", tag, b), good, div);
    end
    chk({tag, " early_done"}, dones, 0);
    chk({tag, " done"}, 32'(done_v[sel]), 32'd1);
    chk({tag, " ready_end"}, 32'(ready_v[sel]), 32'd1);
    chk({tag, " busy_end"}, 32'(busy_v[sel]), 32'd0);
    chk({tag, " line_end"}, 32'(tx_d_v[sel]), 32'd1);
  endtask

  // Line must stay idle-high, not busy and without done for n cycles.
  task automatic idle_check(input string tag, input int n);
    int ok;
    ok = 0;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (tx_d_v[sel] === 1'b1 && busy_v[sel] === 1'b0 && done_v[sel] === 1'b0) ok++;
      @(negedge clk);
    end
    chk({tag, " idle"}, ok, n);
  endtask

  initial begin
    rst_n = 1'b0;
    tv    = 1'b0;
    sb    = 1'b0;
    td    = 8'h00;
    sel   = 0;
    repeat (3) @(negedge clk);
    chk("rst tx_d", 32'(tx_d_v), 32'hF);
    chk("rst busy", 32'(busy_v), 32'h0);
    chk("rst done", 32'(done_v), 32'h0);
    chk("rst ready", 32'(ready_v), 32'hF);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst tx_d", 32'(tx_d_v), 32'hF);

    sel = 0;
    run_frame("a5_8n1", 434, 10, 16'h034A, 8'hA5, 1'b0);
    idle_check("a5", 20);

    sel = 1;
    run_frame("41_7e2", 434, 11, 16'h0682, 8'h41, 1'b0);
    idle_check("7e2", 10);

    sel = 2;
    run_frame("41_7o2", 434, 11, 16'h0782, 8'h41, 1'b0);
    idle_check("7o2", 10);

    sel = 0;
    run_frame("b2b_00", 434, 10, 16'h0200, 8'h00, 1'b1);
    run_frame("b2b_ff", 434, 10, 16'h03FE, 8'hFF, 1'b0);
    idle_check("b2b", 30);

    td = 8'hA5;
    tv = 1'b1;
    @(negedge clk);
    tv = 1'b0;
    repeat (4 * 434 + 200) @(negedge clk);
    chk("mid busy", 32'(busy_v[0]), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst tx_d", 32'(tx_d_v[0]), 32'd1);
    chk("mrst busy", 32'(busy_v[0]), 32'd0);
    chk("mrst ready", 32'(ready_v[0]), 32'd1);
    chk("mrst done", 32'(done_v[0]), 32'd0);
    rst_n = 1'b1;
    idle_check("mrst", 10);
    run_frame("3c_after_rst", 434, 10, 16'h0278, 8'h3C, 1'b0);

    sel = 3;
    idle_check("div4_pre", 4);
    run_frame("01_div4", 4, 10, 16'h0202, 8'h01, 1'b0);
    idle_check("div4", 10);

`ifdef UART_TX_BREAK_EN
    begin
      int lowc;
      int hic;
      int dones;
      sel = 0;
      idle_check("brk_pre", 4);
      sb = 1'b1;
      tv = 1'b1;
      td = 8'h55;
      @(negedge clk);
      tv = 1'b0;
      chk("brk busy", 32'(busy_v[0]), 32'd1);
      chk("brk ready", 32'(ready_v[0]), 32'd0);
      lowc  = 0;
      dones = 0;
      for (int i = 0; i < 10000 && tx_d_v[0] === 1'b0; i++) begin
        if (i == 100) sb = 1'b0;
        if (done_v[0] === 1'b1) dones++;
        lowc++;
        @(negedge clk);
      end
      sb = 1'b0;
      chk("brk low_len", lowc, 4340);
      hic = 0;
      for (int i = 0; i < 1000 && busy_v[0] === 1'b1; i++) begin
        if (tx_d_v[0] === 1'b1) hic++;
        if (done_v[0] === 1'b1) dones++;
        @(negedge clk);
      end
      chk("brk high_len", hic, 434);
      chk("brk no_done", dones, 0);
      chk("brk ready_end", 32'(ready_v[0]), 32'd1);
      idle_check("brk_post", 10);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
